// File: rtl/fsb_waitstate_pkg.sv
// Shared definitions for the fast-side bus cycle controller: region codes,
// one-hot state encoding, decode boundaries and wait-count helpers.
package fsb_waitstate_pkg;

    localparam logic [1:0] REG_RAM = 2'd0;
    localparam logic [1:0] REG_ROM = 2'd1;
    localparam logic [1:0] REG_IO  = 2'd2;

    // RAM occupies A[23:22]==00; ROM is the single 1 MB slot at A[23:20]==4.
    localparam logic [1:0] RAM_A_HI = 2'b00;
    localparam logic [3:0] ROM_A    = 4'h4;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_WAIT   = 5'b00010,
        S_IOWAIT = 5'b00100,
        S_ACK    = 5'b01000,
        S_ERR    = 5'b10000
    } state_t;

    function automatic logic [1:0] decode_region(input logic [3:0] a);
        if (a[3:2] == RAM_A_HI)
            return REG_RAM;
        else if (a == ROM_A)
            return REG_ROM;
        else
            return REG_IO;
    endfunction

    function automatic logic [3:0] ws_load(input logic [3:0] base, input logic [3:0] extra,
                                           input logic en);
        return en ? (base + extra) : base;
    endfunction

endpackage

// File: rtl/fsb_waitstate_ws_counter.sv
// 4-bit loadable wait-state down-counter; stops at zero and flags it.
module fsb_waitstate_ws_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic [3:0] o_count,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= 4'd0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && (r_count != 4'd0))
            r_count <= r_count - 4'd1;
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == 4'd0);

endmodule

// File: rtl/fsb_waitstate.sv
// Fast-side bus cycle controller: decodes each nAS cycle into RAM/ROM/IO,
// counts wait states, hands IO cycles to the bridge and returns nDTACK or nBERR.
module fsb_waitstate
    import fsb_waitstate_pkg::*;
#(
    parameter int RAM_WS_BASE  = 0,
    parameter int RAM_WS_EXTRA = 1,
    parameter int ROM_WS_BASE  = 1,
    parameter int ROM_WS_EXTRA = 2,
    parameter int IO_WS_EXTRA  = 2,
    parameter int IO_TIMEOUT   = 255
) (
    input  logic       FCLK,
    input  logic       nRES,
    input  logic       nAS,
    input  logic [3:0] A,
    input  logic       ROMWS,
    input  logic       RAMWS,
    input  logic       IOWS,
    input  logic       IOACK,
    output logic       IOREQ,
    output logic       RAMCS,
    output logic       ROMCS,
    output logic       nDTACK,
    output logic       nBERR,
    output logic [4:0] o_dbg_state
);

    generate
        if (RAM_WS_BASE + RAM_WS_EXTRA > 15) begin : g_bad_ram
            $error("fsb_waitstate: RAM wait-state sum exceeds 4-bit counter");
        end
        if (ROM_WS_BASE + ROM_WS_EXTRA > 15) begin : g_bad_rom
            $error("fsb_waitstate: ROM wait-state sum exceeds 4-bit counter");
        end
        if (IO_WS_EXTRA > 15) begin : g_bad_io
            $error("fsb_waitstate: IO wait-state count exceeds 4-bit counter");
        end
        if (IO_TIMEOUT > 255 || IO_TIMEOUT < 1) begin : g_bad_timeout
            $error("fsb_waitstate: IO_TIMEOUT must be within 1..255");
        end
    endgenerate

    localparam logic [3:0] RAM_BASE_W  = 4'(RAM_WS_BASE);
    localparam logic [3:0] RAM_EXTRA_W = 4'(RAM_WS_EXTRA);
    localparam logic [3:0] ROM_BASE_W  = 4'(ROM_WS_BASE);
    localparam logic [3:0] ROM_EXTRA_W = 4'(ROM_WS_EXTRA);
    localparam logic [3:0] IO_EXTRA_W  = 4'(IO_WS_EXTRA);
    localparam logic [7:0] TIMEOUT_W   = 8'(IO_TIMEOUT);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_region, w_region_nxt, w_dec_region;
    logic       r_iows, w_iows_nxt;
    logic [7:0] r_tcnt, w_tcnt_nxt, w_tcnt_inc;
    logic       w_ld, w_dec, w_wzero;
    logic [3:0] w_ld_val, w_wcnt, w_ram_ws, w_rom_ws, w_io_ws;

    fsb_waitstate_ws_counter u_ws_counter (
        .clk        (FCLK),
        .rst_n      (nRES),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_count    (w_wcnt),
        .o_zero     (w_wzero)
    );

    assign w_dec_region = decode_region(A);
    assign w_ram_ws     = ws_load(RAM_BASE_W, RAM_EXTRA_W, RAMWS);
    assign w_rom_ws     = ws_load(ROM_BASE_W, ROM_EXTRA_W, ROMWS);
    assign w_io_ws      = r_iows ? IO_EXTRA_W : 4'd0;
    assign w_tcnt_inc   = (r_tcnt == 8'hFF) ? 8'hFF : (r_tcnt + 8'd1);

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_state  <= S_IDLE;
            r_region <= REG_RAM;
            r_iows   <= 1'b0;
            r_tcnt   <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_region <= w_region_nxt;
            r_iows   <= w_iows_nxt;
            r_tcnt   <= w_tcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_iows_nxt   = r_iows;
        w_tcnt_nxt   = r_tcnt;
        w_ld         = 1'b0;
        w_ld_val     = 4'd0;
        w_dec        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!nAS) begin
                    w_region_nxt = w_dec_region;
                    w_iows_nxt   = IOWS;
                    if (w_dec_region == REG_RAM) begin
                        w_ld        = 1'b1;
                        w_ld_val    = w_ram_ws;
                        w_state_nxt = (w_ram_ws == 4'd0) ? S_ACK : S_WAIT;
                    end else if (w_dec_region == REG_ROM) begin
                        w_ld        = 1'b1;
                        w_ld_val    = w_rom_ws;
                        w_state_nxt = (w_rom_ws == 4'd0) ? S_ACK : S_WAIT;
                    end else begin
                        w_tcnt_nxt  = 8'd0;
                        w_state_nxt = S_IOWAIT;
                    end
                end
            end
            S_WAIT: begin
                if (nAS)
                    w_state_nxt = S_IDLE;
                else if (w_wzero || (w_wcnt == 4'd1))
                    w_state_nxt = S_ACK;
                else
                    w_dec = 1'b1;
            end
            S_IOWAIT: begin
                w_tcnt_nxt = w_tcnt_inc;
                // An acknowledge arriving on the timeout edge still completes normally.
                if (nAS) begin
                    w_state_nxt = S_IDLE;
                end else if (IOACK) begin
                    w_ld        = 1'b1;
                    w_ld_val    = w_io_ws;
                    w_state_nxt = (w_io_ws == 4'd0) ? S_ACK : S_WAIT;
                end else if (w_tcnt_inc == TIMEOUT_W) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ACK, S_ERR: begin
                if (nAS)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state and region flops, so they are glitch-free.
    assign IOREQ       = (r_state == S_IOWAIT);
    assign RAMCS       = (r_state != S_IDLE) && (r_region == REG_RAM);
    assign ROMCS       = (r_state != S_IDLE) && (r_region == REG_ROM);
    assign nDTACK      = (r_state != S_ACK);
    assign nBERR       = (r_state != S_ERR);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fsb_waitstate.sv
// Directed bench for fsb_waitstate: table of RAM/ROM/IO cycles plus
// hand-written timeout, abort, reset and ack-vs-timeout sequences.
module tb_fsb_waitstate;

    logic       FCLK = 1'b0;
    logic       nRES = 1'b0;
    logic       nAS = 1'b1;
    logic [3:0] A = 4'h0;
    logic       ROMWS = 1'b0;
    logic       RAMWS = 1'b0;
    logic       IOWS = 1'b0;
    logic       IOACK = 1'b0;
    logic       IOREQ, RAMCS, ROMCS, nDTACK, nBERR;
    logic [4:0] o_dbg_state;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [4:0] ST_IDLE = 5'b00001;

    typedef struct {
        logic [3:0] a;
        logic       ramws;
        logic       romws;
        logic       iows;
        int         ack_dly;
        logic       exp_ramcs;
        logic       exp_romcs;
        logic       exp_ioreq;
        int         exp_edges;
    } vec_t;

    vec_t vecs[8];

    fsb_waitstate dut (
        .FCLK        (FCLK),
        .nRES        (nRES),
        .nAS         (nAS),
        .A           (A),
        .ROMWS       (ROMWS),
        .RAMWS       (RAMWS),
        .IOWS        (IOWS),
        .IOACK       (IOACK),
        .IOREQ       (IOREQ),
        .RAMCS       (RAMCS),
        .ROMCS       (ROMCS),
        .nDTACK      (nDTACK),
        .nBERR       (nBERR),
        .o_dbg_state (o_dbg_state)
    );

    always #5 FCLK = ~FCLK;

    task automatic tick();
        @(posedge FCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic start_cycle(input logic [3:0] a, input logic ramws, input logic romws,
                               input logic iows);
        A     = a;
        RAMWS = ramws;
        ROMWS = romws;
        IOWS  = iows;
        nAS   = 1'b0;
    endtask

    task automatic end_cycle(input string tag);
        nAS = 1'b1;
        tick();
        check({tag, "_release_ndtack"}, 32'(nDTACK), 32'd1);
        check({tag, "_release_nberr"}, 32'(nBERR), 32'd1);
        check({tag, "_release_cs"}, {29'd0, RAMCS, ROMCS, IOREQ}, 32'd0);
        check({tag, "_release_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        int n;

        // a, ramws, romws, iows, ack_dly, ramcs, romcs, ioreq, edges-to-nDTACK
        vecs[0] = '{4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{4'h3, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2};
        vecs[2] = '{4'h4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 2};
        vecs[3] = '{4'h4, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4};
        vecs[4] = '{4'h2, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{4'hE, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1, 3};
        vecs[6] = '{4'h8, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1};
        vecs[7] = '{4'h5, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1, 3};

        #12;
        check("reset_ndtack", 32'(nDTACK), 32'd1);
        check("reset_nberr", 32'(nBERR), 32'd1);
        check("reset_cs", {29'd0, RAMCS, ROMCS, IOREQ}, 32'd0);
        check("reset_state", 32'(o_dbg_state), 32'(ST_IDLE));
        #1 nRES = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) begin
            start_cycle(vecs[i].a, vecs[i].ramws, vecs[i].romws, vecs[i].iows);
            tick();
            check($sformatf("v%0d_first_cs", i), {29'd0, RAMCS, ROMCS, IOREQ},
                  {29'd0, vecs[i].exp_ramcs, vecs[i].exp_romcs, vecs[i].exp_ioreq});
            if (vecs[i].exp_ioreq) begin
                repeat (vecs[i].ack_dly) tick();
                check($sformatf("v%0d_ioreq_held", i), 32'(IOREQ), 32'd1);
                IOACK = 1'b1;
                tick();
                IOACK = 1'b0;
                n = 1;
                check($sformatf("v%0d_ioreq_drop", i), 32'(IOREQ), 32'd0);
            end else begin
                n = 1;
            end
            while (nDTACK && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].exp_edges));
            check($sformatf("v%0d_ack_nberr", i), 32'(nBERR), 32'd1);
            check($sformatf("v%0d_ack_cs", i), {30'd0, RAMCS, ROMCS},
                  {30'd0, vecs[i].exp_ramcs, vecs[i].exp_romcs});
            tick();
            check($sformatf("v%0d_ack_hold", i), 32'(nDTACK), 32'd0);
            end_cycle($sformatf("v%0d", i));
        end

        // IO timeout: no acknowledge ever arrives.
        start_cycle(4'h5, 1'b0, 1'b0, 1'b0);
        tick();
        n = 0;
        while (nBERR && n < 400) begin
            tick();
            n++;
        end
        check("timeout_edges", 32'(n), 32'd255);
        check("timeout_ndtack", 32'(nDTACK), 32'd1);
        check("timeout_ioreq", 32'(IOREQ), 32'd0);
        repeat (3) tick();
        check("timeout_nberr_hold", 32'(nBERR), 32'd0);
        end_cycle("timeout");

        // ROM cycle aborted in WAIT, then a normal RAM cycle.
        start_cycle(4'h4, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("abort_romcs_before", 32'(ROMCS), 32'd1);
        nAS = 1'b1;
        tick();
        check("abort_romcs", 32'(ROMCS), 32'd0);
        check("abort_state", 32'(o_dbg_state), 32'(ST_IDLE));
        repeat (3) tick();
        check("abort_no_ndtack", 32'(nDTACK), 32'd1);
        start_cycle(4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("abort_next_ram_ndtack", 32'(nDTACK), 32'd0);
        check("abort_next_ram_cs", 32'(RAMCS), 32'd1);
        end_cycle("abort_next");

        // IO cycle aborted in IOWAIT.
        start_cycle(4'h9, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        nAS = 1'b1;
        tick();
        check("ioabort_ioreq", 32'(IOREQ), 32'd0);
        check("ioabort_flags", {30'd0, nDTACK, nBERR}, 32'd3);

        // Asynchronous reset while in IOWAIT, observed between clock edges.
        start_cycle(4'hE, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check("rst_ioreq_before", 32'(IOREQ), 32'd1);
        nRES = 1'b0;
        #1;
        check("rst_async_ioreq", 32'(IOREQ), 32'd0);
        check("rst_async_flags", {30'd0, nDTACK, nBERR}, 32'd3);
        check("rst_async_state", 32'(o_dbg_state), 32'(ST_IDLE));
        nAS = 1'b1;
        #1 nRES = 1'b1;
        tick();

        // IOACK on the very edge the timeout would fire.
        start_cycle(4'h5, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (254) tick();
        check("race_pre_nberr", 32'(nBERR), 32'd1);
        check("race_pre_ioreq", 32'(IOREQ), 32'd1);
        IOACK = 1'b1;
        tick();
        IOACK = 1'b0;
        check("race_ndtack", 32'(nDTACK), 32'd0);
        check("race_nberr", 32'(nBERR), 32'd1);
        end_cycle("race");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
